rbm_avm_master: RTL and testbench

- Avalon-MM master that drives the RBM compute slave (avs_s0) from a simple command/response stream.
- Per command: writes one DATA_WIDTH word to the slave, waits a fixed settle time for the slave's internal pipeline, reads the result back, and returns it on the response port.
- Sits between the host-side control logic (or a test sequencer) and the RBM slave in the Qsys system.

---
 rtl/rbm_avm_pkg.sv | 23 ++
 rtl/rbm_avm_delay_counter.sv | 25 ++
 rtl/rbm_avm_master.sv | 179 +++++++++++++++++
 tb/tb_rbm_avm_master.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rbm_avm_pkg.sv
// rbm_avm_pkg: shared state encoding and counter widths for the RBM Avalon-MM master
package rbm_avm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SETTLE,
        READ,
        WAIT_DATA,
        RESP
    } state_e;

    localparam int SETTLE_W = 8;
    localparam int LAT_W    = 4;
    localparam int TMO_W    = 8;

    // Counter reload value: the FSM leaves SETTLE/WAIT_DATA on the edge it sees zero,
    // so n waiting cycles need a reload of n-1.
    function automatic logic [SETTLE_W-1:0] ld_val(input int n);
        return (n > 0) ? SETTLE_W'(n - 1) : '0;
    endfunction

endpackage

// File: rtl/rbm_avm_delay_counter.sv
// rbm_avm_delay_counter: loadable down-counter with a zero flag, shared by SETTLE and WAIT_DATA
module rbm_avm_delay_counter
    import rbm_avm_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign zero_o = cnt_q == '0;

    // Load takes priority; otherwise count down while enabled and stop at zero
    always_comb cnt_d = load_i ? load_val_i : (en_i && !zero_o) ? cnt_q - W'(1) : cnt_q;

    // Count register
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;

endmodule

// File: rtl/rbm_avm_master.sv
// rbm_avm_master: command/response to Avalon-MM bridge: write one word, settle, read it back.
// Optional waitrequest watchdog enabled by defining RBM_AVM_TIMEOUT_EN.
module rbm_avm_master
    import rbm_avm_pkg::*;
#(
    parameter int DATA_WIDTH     = 256,
    parameter int ADDR_WIDTH     = 4,
    parameter int SETTLE_CYCLES  = 3,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_error,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] avm_m0_address,
    output logic                  avm_m0_write,
    output logic [DATA_WIDTH-1:0] avm_m0_writedata,
    output logic                  avm_m0_read,
    input  logic [DATA_WIDTH-1:0] avm_m0_readdata,
    input  logic                  avm_m0_waitrequest
);

    localparam logic [SETTLE_W-1:0] SET_LD = ld_val(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] LAT_LD = ld_val(READ_LATENCY);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  write_q;
    logic                  read_q;
    logic                  rsp_valid_q;
    logic                  dly_load;
    logic                  dly_en;
    logic                  dly_zero;
    logic [SETTLE_W-1:0]   dly_val;
    logic                  tmo_hit;

    assign cmd_ready        = (state_q == IDLE) && !reset;
    assign busy             = state_q != IDLE;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign avm_m0_address   = addr_q;
    assign avm_m0_write     = write_q;
    assign avm_m0_writedata = wdata_q;
    assign avm_m0_read      = read_q;

    // Delay counter is loaded on the same edge the slave accepts a strobe
    always_comb begin
        dly_load = (state_q == WRITE || state_q == READ) && !avm_m0_waitrequest;
        dly_val  = (state_q == WRITE) ? SET_LD : LAT_LD;
        dly_en   = state_q == SETTLE || state_q == WAIT_DATA;
    end

    rbm_avm_delay_counter #(.W(SETTLE_W)) u_dly (
        .clk        (clk),
        .reset      (reset),
        .load_i     (dly_load),
        .load_val_i (dly_val),
        .en_i       (dly_en),
        .zero_o     (dly_zero)
    );

`ifdef RBM_AVM_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [TMO_W-1:0] tmo_q;
    logic             rsp_error_q;
    logic             stall;

    assign stall     = (state_q == WRITE || state_q == READ) && avm_m0_waitrequest;
    assign tmo_hit   = stall && tmo_q == TMO_LAST;
    assign rsp_error = rsp_error_q;

    // Stall watchdog; clears whenever the stall ends, which covers every state change
    always_ff @(posedge clk) begin
        tmo_q       <= (reset || !stall || tmo_hit) ? '0 : tmo_q + TMO_W'(1);
        rsp_error_q <= reset ? 1'b0 : tmo_hit ? 1'b1 : (state_q == RESP && rsp_ready) ? 1'b0 : rsp_error_q;
    end
`else
    assign tmo_hit   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    // Transaction FSM with registered strobes and response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_data;
                        write_q <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (tmo_hit) begin
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= RESP;
                    end else if (!avm_m0_waitrequest) begin
                        write_q <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                            read_q  <= 1'b1;
                            state_q <= READ;
                        end else begin
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (dly_zero) begin
                        read_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (tmo_hit) begin
                        read_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= RESP;
                    end else if (!avm_m0_waitrequest) begin
                        read_q <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            rsp_data_q  <= avm_m0_readdata;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            state_q <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (dly_zero) begin
                        rsp_data_q  <= avm_m0_readdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_excl: assert property (@(posedge clk) disable iff (reset) !(avm_m0_read && avm_m0_write));

`ifndef RBM_AVM_TIMEOUT_EN
    a_wr_hold: assert property (@(posedge clk) disable iff (reset)
        avm_m0_write && avm_m0_waitrequest |=> avm_m0_write && $stable(avm_m0_address) && $stable(avm_m0_writedata));
    a_rd_hold: assert property (@(posedge clk) disable iff (reset)
        avm_m0_read && avm_m0_waitrequest |=> avm_m0_read && $stable(avm_m0_address));
`endif

endmodule

// File: tb/tb_rbm_avm_master.sv
// tb_rbm_avm_master: directed self-checking bench for rbm_avm_master with a latency-2 slave model
module tb_rbm_avm_master;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_addr = '0;
    logic [255:0] cmd_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [255:0] rsp_data;
    logic         rsp_error;
    logic         busy;
    logic [3:0]   avm_m0_address;
    logic         avm_m0_write;
    logic [255:0] avm_m0_writedata;
    logic         avm_m0_read;
    logic [255:0] avm_m0_readdata;
    logic         avm_m0_waitrequest = 1'b0;

    logic [255:0] slv_rd = '0;
    logic [255:0] p1, p2;
    logic [255:0] ones;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    rbm_avm_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_data           (cmd_data),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_data           (rsp_data),
        .rsp_error          (rsp_error),
        .busy               (busy),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_read        (avm_m0_read),
        .avm_m0_readdata    (avm_m0_readdata),
        .avm_m0_waitrequest (avm_m0_waitrequest)
    );

    // Slave model: data is valid only at the edge two cycles after read accept, zero otherwise
    always @(posedge clk) begin
        p1 <= (avm_m0_read && !avm_m0_waitrequest) ? (slv_rd ^ 256'(avm_m0_address)) : '0;
        p2 <= p1;
    end
    assign avm_m0_readdata = p2;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction: stalls wst/rst_ cycles on write/read, holds rsp_ready low rdy cycles
    task automatic run(input string tag, input logic [3:0] a, input logic [255:0] d,
                       input int wst, input int rst_, input int rdy, input bit keep,
                       input logic [3:0] na, input logic [255:0] nd,
                       input int exp_lat, input int exp_rc, input logic [255:0] exp_data, input logic exp_err);
        int t, wc, rc, w_at, r_at, k;
        bit ok;
        logic [255:0] held;
        cmd_addr = a;
        cmd_data = d;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".accept"}, 256'(cmd_ready), 256'(1));
        @(negedge clk);
        if (keep) begin
            cmd_addr = na;
            cmd_data = nd;
        end else begin
            cmd_valid = 1'b0;
        end
        t = 0; wc = 0; rc = 0; w_at = -1; r_at = -1; ok = 1'b1;
        while (!rsp_valid && t < 200) begin
            if (avm_m0_write) begin
                if (w_at < 0) w_at = t;
                wc++;
                ok = ok && avm_m0_address == a && avm_m0_writedata == d && !avm_m0_read;
            end
            if (avm_m0_read) begin
                if (r_at < 0) r_at = t;
                rc++;
                ok = ok && avm_m0_address == a;
            end
            ok = ok && !cmd_ready && busy;
            avm_m0_waitrequest = (avm_m0_write && wc <= wst) || (avm_m0_read && rc <= rst_);
            @(negedge clk);
            t++;
        end
        avm_m0_waitrequest = 1'b0;
        chk({tag, ".latency"}, 256'(t), 256'(exp_lat));
        chk({tag, ".wr_cycles"}, 256'(wc), 256'(wst + 1));
        chk({tag, ".rd_cycles"}, 256'(rc), 256'(exp_rc));
        chk({tag, ".rd_gap"}, 256'(r_at - w_at), 256'(wst + 4));
        chk({tag, ".strobes"}, 256'(ok), 256'(1));
        chk({tag, ".rsp_data"}, rsp_data, exp_data);
        chk({tag, ".rsp_error"}, 256'(rsp_error), 256'(exp_err));
        chk({tag, ".rd_drop"}, 256'({avm_m0_read, avm_m0_write}), 256'(0));
        held = rsp_data;
        ok = 1'b1;
        repeat (rdy) begin
            @(negedge clk);
            ok = ok && rsp_valid && rsp_data == held && !cmd_ready && !avm_m0_read && !avm_m0_write;
        end
        chk({tag, ".rsp_hold"}, 256'(ok), 256'(1));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".idle"}, 256'({rsp_valid, busy, cmd_ready}), 256'(3'b001));
    endtask

    initial begin
        bit ok;
        ones = '1;
        repeat (3) @(negedge clk);
        chk("reset.outs", 256'({cmd_ready, busy, rsp_valid, rsp_error, avm_m0_write, avm_m0_read}), 256'(0));
        chk("reset.rsp_data", rsp_data, 256'(0));
        chk("reset.addr", 256'(avm_m0_address), 256'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle.ready", 256'({cmd_ready, busy}), 256'(2'b10));

        slv_rd = 256'h3;
        run("single", 4'd0, ones, 0, 0, 0, 1'b0, 4'd0, '0, 7, 1, 256'h3, 1'b0);

        slv_rd = 256'h30;
        run("stall", 4'd5, 256'hDEAD_BEEF_0123, 5, 3, 0, 1'b0, 4'd0, '0, 15, 4, 256'h35, 1'b0);

        slv_rd = 256'h100;
        run("bp", 4'd2, 256'h77, 0, 0, 10, 1'b0, 4'd0, '0, 7, 1, 256'h102, 1'b0);

        cmd_addr = 4'd9;
        cmd_data = 256'h1234;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst.in_settle", 256'({busy, avm_m0_write, avm_m0_read}), 256'(3'b100));
        reset = 1'b1;
        @(negedge clk);
        chk("rst.after", 256'({avm_m0_write, avm_m0_read, rsp_valid, busy, cmd_ready}), 256'(0));
        reset = 1'b0;
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            ok = ok && !rsp_valid && !avm_m0_read && !avm_m0_write && !busy;
        end
        chk("rst.no_rsp", 256'(ok), 256'(1));
        slv_rd = 256'h77;
        run("post_rst", 4'd1, 256'h5A, 0, 0, 0, 1'b0, 4'd0, '0, 7, 1, 256'h76, 1'b0);

        slv_rd = 256'hA0;
        run("b2b1", 4'd3, 256'h11, 0, 0, 2, 1'b1, 4'd4, 256'h22, 7, 1, 256'hA3, 1'b0);
        run("b2b2", 4'd4, 256'h22, 0, 0, 0, 1'b0, 4'd0, '0, 7, 1, 256'hA4, 1'b0);

`ifdef RBM_AVM_TIMEOUT_EN
        slv_rd = 256'hFF;
        run("tmo", 4'd6, 256'h99, 0, 1000, 0, 1'b0, 4'd0, '0, 20, 16, 256'h0, 1'b1);
        slv_rd = 256'h40;
        run("tmo_after", 4'd1, 256'h5, 0, 0, 0, 1'b0, 4'd0, '0, 7, 1, 256'h41, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
